serial_word_receiver: RTL and testbench

Downstream consumer of the 3-bit parallel-load shift register's serial output `do`. It frames bits arriving on `si` into parallel words of `W` bits, assembling them LSB-first. The first bit shifted out lands in `dout[0]`, so a word loaded upstream is reproduced bit-for-bit. Completed words are presented through a valid/ready handshake, with sticky overrun detection and optional even-parity checking.

---
 rtl/serial_word_receiver_if.sv | 47 ++++
 rtl/serial_word_receiver.sv | 194 +++++++++++++++++++
 tb/tb_serial_word_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_receiver_if.sv
// ---------------------------------------------------------------------------
// serial_word_receiver_if
//
// Bundles the serial input, the framing strobes and the word-side
// valid/ready handshake of serial_word_receiver.
//
// Parameter:
//   W            word width in bits (2..16); must match the receiver's W
//
// Signals:
//   si           serial data bit (from the upstream shift register output)
//   sen          bit strobe, si is sampled only when high
//   start        frame start / restart strobe
//   dout[W-1:0]  assembled word, LSB = first bit received
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout when dout_valid is high
//   busy         receiver is inside a frame
//   overrun      sticky, a completed word was dropped
//   perr         even-parity error attached to dout
//
// Modports:
//   master       the side that drives bits in and consumes words
//   slave        the receiver itself
// ---------------------------------------------------------------------------
interface serial_word_receiver_if #(
    parameter int W = 3
);
    logic         si;
    logic         sen;
    logic         start;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;
    logic         perr;

    modport master (
        output si, sen, start, dout_ready,
        input  dout, dout_valid, busy, overrun, perr
    );

    modport slave (
        input  si, sen, start, dout_ready,
        output dout, dout_valid, busy, overrun, perr
    );
endinterface

// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver
//
// Frames the serial bit stream of an upstream parallel-load shift register
// into W-bit words, LSB first, so a word loaded upstream is reproduced
// bit-for-bit on dout. Finished words are offered on a valid/ready
// handshake; a word that completes while the previous one is still unread
// is dropped and flagged on the sticky overrun output.
//
// Optional feature (compile-time macro PARITY_EN):
//   defined   - each frame carries one extra even-parity bit after the data;
//               perr reports XOR(word, parity bit) alongside dout.
//   undefined - frames are exactly W bits and perr is tied low.
//
// Parameter:
//   W      word width, legal range 2..16
//
// Ports:
//   clk    rising-edge clock
//   clrn   asynchronous active-low clear
//   bus    serial_word_receiver_if.slave (si, sen, start, dout, dout_valid,
//          dout_ready, busy, overrun, perr)
// ---------------------------------------------------------------------------
module serial_word_receiver #(
    parameter int W = 3
) (
    input  logic                   clk,
    input  logic                   clrn,
    serial_word_receiver_if.slave  bus
);
    localparam int             CW   = $clog2(W + 1);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shr;
    logic [W-1:0]  dout_q;
    logic          valid_q;
    logic          busy_q;
    logic          overrun_q;

    // Value the assembly register takes when a bit is sampled: new bits
    // enter at the top, so after W strobes the first bit sits in bit 0.
    logic [W-1:0]  shr_shift;
    assign shr_shift = {bus.si, shr[W-1:1]};

    // A finished word may be stored if the output slot is empty or is being
    // emptied by a handshake on this very edge.
    logic          handshake;
    logic          accept;
    assign handshake = valid_q && bus.dout_ready;
    assign accept    = !valid_q || bus.dout_ready;

    // Word completion detection and the word/parity value it delivers.
    logic          complete;
    logic [W-1:0]  word;
`ifdef PARITY_EN
    logic          word_perr;
    logic          perr_q;
`else
    // The oldest bit falls off the end on the edge that brings in the last
    // one, so without a parity phase shr[0] is never read.
    logic          shr_lsb_unused;
    assign shr_lsb_unused = shr[0];
`endif

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned and no latch is inferred.
        complete = 1'b0;
        word     = shr_shift;
`ifdef PARITY_EN
        word_perr = 1'b0;
`endif
        case (state)
`ifdef PARITY_EN
            PAR: begin
                // Data bits are already in shr; this strobe carries parity.
                word      = shr;
                word_perr = (^shr) ^ bus.si;
                complete  = !bus.start && bus.sen;
            end
`else
            RECV: begin
                complete = !bus.start && bus.sen && (cnt == LAST);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: all state here uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!clrn) begin
            state     <= IDLE;
            cnt       <= '0;
            shr       <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RECV;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end

                RECV: begin
                    if (bus.start) begin
                        // Restart: stale bits in shr are overwritten by the
                        // W fresh bits the new frame must deliver anyway.
                        cnt <= '0;
                    end else if (bus.sen) begin
                        shr <= shr_shift;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
`ifdef PARITY_EN
                            state  <= PAR;
`else
                            state  <= IDLE;
                            busy_q <= 1'b0;
`endif
                        end
                    end
                end

`ifdef PARITY_EN
                PAR: begin
                    if (bus.start) begin
                        state <= RECV;
                        cnt   <= '0;
                    end else if (bus.sen) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // Output slot: a completion takes priority over a plain
            // handshake; a completion that cannot be stored is an overrun.
            if (complete) begin
                if (accept) begin
                    dout_q  <= word;
                    valid_q <= 1'b1;
`ifdef PARITY_EN
                    perr_q  <= word_perr;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
`ifdef PARITY_EN
    assign bus.perr       = perr_q;
`else
    assign bus.perr       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_word_receiver
//
// Bench for serial_word_receiver with W = 3. Inputs change 1 ns after a
// rising edge and outputs are sampled 1 ns after the next one. A reference
// model tracks the frame as an indexed bit array and a bit count and is
// compared against the DUT after every clock. On top of that, a fixed
// vector table and hand-written sequences check explicit expected values.
// Works with and without PARITY_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_word_receiver;
    localparam int W = 3;
`ifdef PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk;
    logic clrn;
    bit   clk_run;

    serial_word_receiver_if #(.W(W)) bus ();

    serial_word_receiver #(.W(W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_dout;
    logic [W-1:0] m_bits;
    logic         m_valid, m_busy, m_ovr, m_perr;
    int           m_n;

    task automatic model_reset();
        m_dout  = '0;
        m_bits  = '0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
        m_n     = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit           done;
        bit           hs;
        logic         pbit;
        logic [W-1:0] w;
        done = 0;
        pbit = 1'b0;
        w    = '0;
        hs   = m_valid && bus.dout_ready;
        if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1'b1;
                m_n    = 0;
            end
        end else if (bus.start) begin
            m_n = 0;
        end else if (bus.sen) begin
            if (m_n < W) m_bits[m_n] = bus.si;
            else         pbit = bus.si;
            m_n++;
            if (m_n == W + PAR_BITS) begin
                done   = 1;
                w      = m_bits;
                m_busy = 1'b0;
            end
        end
        if (done) begin
            if (!m_valid || hs) begin
                m_dout  = w;
                m_valid = 1'b1;
                m_perr  = (PAR_BITS != 0) ? ((^w) ^ pbit) : 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: update model, wait for the edge, compare DUT with model.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("model_dout",  32'(bus.dout),       32'(m_dout));
        check("model_valid", 32'(bus.dout_valid), 32'(m_valid));
        check("model_busy",  32'(bus.busy),       32'(m_busy));
        check("model_ovr",   32'(bus.overrun),    32'(m_ovr));
        check("model_perr",  32'(bus.perr),       32'(m_perr));
    endtask

    task automatic drive(input logic st, input logic sn, input logic s,
                         input logic rd);
        bus.start      = st;
        bus.sen        = sn;
        bus.si         = s;
        bus.dout_ready = rd;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        clrn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    // start, W data bits, optional even parity bit; rdy_last is dout_ready
    // on the completion edge, ready is low everywhere else.
    task automatic send_frame(input logic [W-1:0] w, input logic rdy_last);
        drive(1, 0, 0, 0);
        step();
        for (int i = 0; i < W; i++) begin
            drive(0, 1, w[i], (i == W - 1 && PAR_BITS == 0) ? rdy_last : 1'b0);
            step();
        end
        if (PAR_BITS != 0) begin
            drive(0, 1, ^w, rdy_last);
            step();
        end
        drive(0, 0, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         st, sn, si, rd;
        logic [W-1:0] e_dout;
        logic         e_valid, e_busy, e_ovr, e_perr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic sn,
                                input logic s, input logic rd,
                                input logic [W-1:0] d, input logic v,
                                input logic b, input logic o,
                                input logic p);
        vec_t t;
        t.st = st; t.sn = sn; t.si = s; t.rd = rd;
        t.e_dout = d; t.e_valid = v; t.e_busy = b; t.e_ovr = o; t.e_perr = p;
        vecs.push_back(t);
    endfunction

    logic [2:0] up_q;

    initial begin
        clk_run = 1'b1;
        clrn    = 1'b0;
        drive(0, 0, 0, 0);
        model_reset();

        // Reset values while reset is held.
        @(posedge clk);
        #1;
        check("rst_dout",  32'(bus.dout),       0);
        check("rst_valid", 32'(bus.dout_valid), 0);
        check("rst_busy",  32'(bus.busy),       0);
        check("rst_ovr",   32'(bus.overrun),    0);
        check("rst_perr",  32'(bus.perr),       0);
        clrn = 1'b1;

        // Asynchronous reset mid-frame with the clock stopped.
        drive(1, 0, 0, 0); step();
        drive(0, 1, 1, 0); step();
        check("mid_busy", 32'(bus.busy), 1);
        drive(0, 0, 0, 0);
        clk_run = 1'b0;
        #3;
        clrn = 1'b0;
        #1;
        check("async_dout",  32'(bus.dout),       0);
        check("async_valid", 32'(bus.dout_valid), 0);
        check("async_busy",  32'(bus.busy),       0);
        check("async_ovr",   32'(bus.overrun),    0);
        check("async_perr",  32'(bus.perr),       0);
        model_reset();
        #3;
        clrn    = 1'b1;
        clk_run = 1'b1;
        @(posedge clk);
        #1;
        send_frame(3'b101, 1'b0);
        check("post_rst_dout",  32'(bus.dout),       32'h5);
        check("post_rst_valid", 32'(bus.dout_valid), 1);
        do_reset();

        // Basic word: bits 0,1,1 -> 3'b110.
        add(1, 0, 0, 0, 3'b000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b000, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 1, 0, 0);
`ifdef PARITY_EN
        add(0, 1, 1, 0, 3'b000, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b110, 1, 0, 0, 0);
`else
        add(0, 1, 1, 0, 3'b110, 1, 0, 0, 0);
`endif
        add(0, 0, 0, 1, 3'b110, 0, 0, 0, 0);
        add(0, 0, 0, 1, 3'b110, 0, 0, 0, 0);
        // Gaps and restart: 1,0, restart (strobe ignored), 0,_,0,_,_,1.
        add(1, 0, 0, 0, 3'b110, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b110, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b110, 0, 1, 0, 0);
        add(1, 1, 1, 0, 3'b110, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b110, 0, 1, 0, 0);
        add(0, 0, 0, 0, 3'b110, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b110, 0, 1, 0, 0);
        add(0, 0, 1, 0, 3'b110, 0, 1, 0, 0);
        add(0, 0, 0, 0, 3'b110, 0, 1, 0, 0);
`ifdef PARITY_EN
        add(0, 1, 1, 0, 3'b110, 0, 1, 0, 0);
        add(0, 0, 0, 0, 3'b110, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b100, 1, 0, 0, 0);
        add(0, 0, 0, 1, 3'b100, 0, 0, 0, 0);
        // Data 1,1,0 with parity 0 (good), then parity 1 (bad).
        add(1, 0, 0, 0, 3'b100, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b100, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b100, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b100, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b011, 1, 0, 0, 0);
        add(0, 0, 0, 1, 3'b011, 0, 0, 0, 0);
        add(1, 0, 0, 0, 3'b011, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b011, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b011, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3'b011, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3'b011, 1, 0, 0, 1);
        add(0, 0, 0, 1, 3'b011, 0, 0, 0, 1);
`else
        add(0, 1, 1, 0, 3'b100, 1, 0, 0, 0);
        add(0, 0, 0, 1, 3'b100, 0, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sn, vecs[i].si, vecs[i].rd);
            step();
            check($sformatf("vec%0d_dout", i),  32'(bus.dout),       32'(vecs[i].e_dout));
            check($sformatf("vec%0d_valid", i), 32'(bus.dout_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_busy", i),  32'(bus.busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d_ovr", i),   32'(bus.overrun),    32'(vecs[i].e_ovr));
            check($sformatf("vec%0d_perr", i),  32'(bus.perr),       32'(vecs[i].e_perr));
        end

        // Overrun: second word dropped while the first is unread.
        do_reset();
        send_frame(3'b101, 1'b0);
        check("ovr_first_dout", 32'(bus.dout),    32'h5);
        check("ovr_first_ovr",  32'(bus.overrun), 0);
        send_frame(3'b010, 1'b0);
        check("ovr_drop_dout",  32'(bus.dout),       32'h5);
        check("ovr_drop_valid", 32'(bus.dout_valid), 1);
        check("ovr_drop_ovr",   32'(bus.overrun),    1);

        // Handshake on the completion edge: replaced, no overrun.
        do_reset();
        send_frame(3'b101, 1'b0);
        send_frame(3'b010, 1'b1);
        check("hs_same_dout",  32'(bus.dout),       32'h2);
        check("hs_same_valid", 32'(bus.dout_valid), 1);
        check("hs_same_ovr",   32'(bus.overrun),    0);
        send_frame(3'b111, 1'b0);
        check("hs_then_dout", 32'(bus.dout),    32'h2);
        check("hs_then_ovr",  32'(bus.overrun), 1);

        // Upstream chaining: load 3'b011, then shift out LSB first.
        do_reset();
        up_q = 3'b011;
        drive(1, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, up_q[0], 0);
            step();
            up_q = {1'b0, up_q[2:1]};
        end
        if (PAR_BITS != 0) begin
            drive(0, 1, 1'b0, 0);
            step();
        end
        check("chain_dout",  32'(bus.dout),       32'h3);
        check("chain_valid", 32'(bus.dout_valid), 1);
        check("chain_perr",  32'(bus.perr),       0);

        // Random traffic against the model, reset between segments.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                drive($urandom_range(0, 15) == 0,
                      $urandom_range(0, 2) != 0,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
